axis_fifo: RTL and testbench

Parametrised AXI-stream FIFO, successor to the single-stage stream register: moves words from `idata` to `odata` with a configurable capacity of `DEPTH` words. All outputs are registered (including `iready` and `afull`), and it can transfer one word per clock in each direction. It sits between stream producers and consumers wherever more than two words of elasticity are needed, e.g. between clock-rate-matched pipeline stages and the host/USB bridges.

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_fifo_ram.sv | 30 +++
 rtl/axis_fifo.sv | 159 +++++++++++++++
 tb/tb_axis_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared helpers for the AXI-stream FIFO family.
//   clog2  : ceiling log2 for elaboration-time sizing.
//   size_w : width of a fill-level counter that must represent 0..depth.
//   ptr_w  : width of a pointer into a memory of 'entries' words (min 1).
package axis_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int size_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int entries);
    return (entries <= 1) ? 1 : clog2(entries);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: ENTRIES x WIDTH storage behind the FIFO output register.
//   clock_i  : write clock (rising edge)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (head of queue)
//   rdata_o  : asynchronous read data
// Contents are not reset; the FIFO pointers decide what is valid.
module axis_fifo_ram #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 3,
  parameter int AW      = 2
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: AXI-stream FIFO of DEPTH words (output register included).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   size, afull         : fill level (0..DEPTH) and size >= AFULL flag
//   idata/ivalid/iready : input stream
//   odata/ovalid/oready : output stream
//   flush               : only when AXIS_FIFO_FLUSH_EN is defined; empties
//                         the FIFO at the next edge (reset wins over flush)
// All outputs are registered. odata holds the oldest word; the remaining
// DEPTH-1 words live in axis_fifo_ram with wrapping read/write pointers.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer holds data stable while valid && !ready; likewise odata
// is held stable by this block while ovalid && !oready.
module axis_fifo
  import axis_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  parameter  int AFULL = DEPTH - 1,
  localparam int SW    = size_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [SW-1:0]    size,
  output logic             afull,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic [WIDTH-1:0] odata,
  output logic             ovalid,
  input  logic             oready
`ifdef AXIS_FIFO_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int            MD       = DEPTH - 1;
  localparam int            PW       = ptr_w(MD);
  localparam logic [PW-1:0] PTR_LAST = PW'(MD - 1);

  logic [SW-1:0]    size_q, size_d;
  logic             ovalid_q, ovalid_d;
  logic             iready_q, iready_d;
  logic             afull_q, afull_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             push, pop, load, mem_has, bypass, mem_we, flush_w;

`ifdef AXIS_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Explicit wrap so the memory depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push    = ivalid && iready_q;
    pop     = ovalid_q && oready;
    load    = !ovalid_q || oready;
    // Memory holds words 2..size, so it is non-empty only when size > 1.
    mem_has = size_q > SW'(1);
    // Empty memory: a pushed word goes straight to the output register.
    bypass  = load && !mem_has && push;
    mem_we  = push && !bypass && !flush_w;

    size_d   = size_q + SW'(push) - SW'(pop);
    odata_d  = odata_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (load) begin
      if (mem_has) begin
        odata_d  = mem_rdata;
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (push) begin
        odata_d = idata;
      end
    end
    if (mem_we) wr_ptr_d = ptr_inc(wr_ptr_q);

    if (flush_w) begin
      size_d   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    iready_d = size_d < SW'(DEPTH);
    ovalid_d = size_d != '0;
    afull_d  = size_d >= SW'(AFULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      size_q   <= '0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b1;
      afull_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      size_q   <= size_d;
      ovalid_q <= ovalid_d;
      iready_q <= iready_d;
      afull_q  <= afull_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data path register is deliberately not reset.
  always_ff @(posedge clock) begin
    odata_q <= odata_d;
  end

  axis_fifo_ram #(
    .WIDTH  (WIDTH),
    .ENTRIES(MD),
    .AW     (PW)
  ) u_ram (
    .clock_i(clock),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(idata),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  assign size   = size_q;
  assign afull  = afull_q;
  assign iready = iready_q;
  assign ovalid = ovalid_q;
  assign odata  = odata_q;

`ifdef FORMAL
  logic seen_reset_q;
  always_ff @(posedge clock) begin
    if (reset) seen_reset_q <= 1'b1;
  end

  a_iready: assert property (@(posedge clock) disable iff (reset || !seen_reset_q)
    iready_q == (size_q < SW'(DEPTH)));
  a_ovalid: assert property (@(posedge clock) disable iff (reset || !seen_reset_q)
    ovalid_q == (size_q != '0));
  a_live:   assert property (@(posedge clock) disable iff (reset || !seen_reset_q)
    iready_q || ovalid_q);
  a_size:   assert property (@(posedge clock) disable iff (reset || !seen_reset_q)
    !flush_w |=> (reset || size_q == $past(size_q + SW'(push) - SW'(pop))));
  a_stable: assert property (@(posedge clock) disable iff (reset || !seen_reset_q)
    (ovalid_q && !oready && !flush_w) |=> (reset || odata_q == $past(odata_q)));
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: randomized and directed stimulus for axis_fifo against a
// queue-based reference model of the FIFO contents.
module tb_axis_fifo;
  import axis_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;
  localparam int SW    = size_w(DEPTH);

  logic          clock, reset;
  logic [SW-1:0] size;
  logic          afull, iready, ovalid;
  logic [W-1:0]  idata, odata;
  logic          ivalid, oready;
  logic          flush;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  axis_fifo #(.WIDTH(W), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clock (clock),
    .reset (reset),
    .size  (size),
    .afull (afull),
    .idata (idata),
    .ivalid(ivalid),
    .iready(iready),
    .odata (odata),
    .ovalid(ovalid),
    .oready(oready)
`ifdef AXIS_FIFO_FLUSH_EN
    ,
    .flush (flush)
`endif
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           check_en = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  int           m_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is just an ordered list of at most DEPTH words.
  always @(posedge clock) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      m_n = exp_q.size();
      if (oready && m_n > 0) begin
        out_log.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (ivalid && m_n < DEPTH) exp_q.push_back(idata);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clock) begin
    if (check_en) begin
      chk("size", 32'(size), exp_q.size());
      chk("ovalid", 32'(ovalid), 32'(exp_q.size() > 0));
      chk("iready", 32'(iready), 32'(exp_q.size() < DEPTH));
      chk("afull", 32'(afull), 32'(exp_q.size() >= AFULL));
      if (exp_q.size() > 0) chk("odata", 32'(odata), 32'(exp_q[0]));
    end
  end

  // ---------------- driver ----------------
  bit accepted;

  // Apply inputs for one edge; returns at the following falling edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    logic snap;
    snap   = iready;
    ivalid = v;
    idata  = d;
    oready = r;
    @(posedge clock);
    accepted = v && snap;
    @(negedge clock);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    logic         v;
    bit           pending;
    int           words, cyc;

    reset = 1'b1; flush = 1'b0; ivalid = 1'b0; idata = '0; oready = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    reset = 1'b0;
    check_en = 1;

    // Reset state
    chk("rst_size", 32'(size), 0);
    chk("rst_ovalid", 32'(ovalid), 0);
    chk("rst_iready", 32'(iready), 1);
    chk("rst_afull", 32'(afull), 0);

    // Single word through an empty FIFO: one-cycle latency
    drive(1, 8'h11, 1);
    chk("first_odata", 32'(odata), 32'h11);
    chk("first_ovalid", 32'(ovalid), 1);
    drive(0, 0, 1);
    chk("first_drained", 32'(size), 0);

    // Fill with oready low: only four of five accepted
    for (int i = 1; i <= 5; i++) begin
      drive(1, W'(i), 0);
      if (i == 2) chk("fill_afull_lo", 32'(afull), 0);
      if (i == 3) chk("fill_afull_hi", 32'(afull), 1);
      if (i == 5) chk("fill_5th_rejected", 32'(accepted), 0);
    end
    chk("full_size", 32'(size), 4);
    chk("full_iready", 32'(iready), 0);
    chk("full_odata", 32'(odata), 32'h01);

    // Stream from full: one word out per cycle, producer holds until accepted
    out_log.delete();
    d = 8'h20;
    for (int i = 0; i < 20; i++) begin
      drive(1, d, 1);
      if (accepted) d++;
    end
    chk("stream_count", out_log.size(), 20);
    chk("stream_w0", 32'(out_log[0]), 32'h01);
    chk("stream_w3", 32'(out_log[3]), 32'h04);
    chk("stream_w4", 32'(out_log[4]), 32'h20);
    chk("stream_w19", 32'(out_log[19]), 32'h2F);
    chk("stream_size", 32'(size), 3);
    repeat (6) drive(0, 0, 1);

    // Random traffic
    words = 0; cyc = 0; pending = 0; v = 0; d = '0;
    while (words < 4000 && cyc < 60000) begin
      if (!pending) begin
        v = 1'($urandom_range(0, 1));
        d = W'($urandom);
      end
      drive(v, d, 1'($urandom_range(0, 1)));
      cyc++;
      if (accepted) words++;
      pending = v && !accepted;
    end
    chk("random_words", words, 4000);
    repeat (6) drive(0, 0, 1);

    // Reset mid-operation with a beat presented during reset
    drive(1, 8'h31, 0);
    drive(1, 8'h32, 0);
    drive(1, 8'h33, 0);
    chk("pre_reset_size", 32'(size), 3);
    reset = 1'b1;
    drive(1, 8'h55, 0);
    reset = 1'b0;
    chk("post_reset_size", 32'(size), 0);
    chk("post_reset_ovalid", 32'(ovalid), 0);
    chk("post_reset_iready", 32'(iready), 1);
    drive(1, 8'hAA, 0);
    drive(1, 8'hBB, 0);
    chk("post_reset_first", 32'(odata), 32'hAA);
    chk("post_reset_size2", 32'(size), 2);

`ifdef AXIS_FIFO_FLUSH_EN
    flush = 1'b1;
    drive(1, 8'h77, 1);
    flush = 1'b0;
    chk("flush_size", 32'(size), 0);
    chk("flush_ovalid", 32'(ovalid), 0);
    drive(1, 8'h78, 1);
    chk("flush_next_word", 32'(odata), 32'h78);
`endif

    repeat (6) drive(0, 0, 1);
    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
